dram_port_arbiter: RTL

//  Multi-client front end for the single DDR3 app interface (MIG-style cmd/wdata/rdata channels).

---
 rtl/dram_port_arbiter_pkg.sv | 11 +
 rtl/dram_port_arbiter_owner_fifo.sv | 49 ++++
 rtl/dram_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared DDR3 app-interface constants for the DRAM port arbiter.
// Command codes follow the MIG app_cmd encoding.
package dram_port_arbiter_pkg;

   localparam logic [2:0] DDR3CMD_WRITE = 3'b000;
   localparam logic [2:0] DDR3CMD_READ  = 3'b001;

   localparam int DDR_DWIDTH = 512;
   localparam int DDR_MWIDTH = DDR_DWIDTH / 8;

endpackage

// File: rtl/dram_port_arbiter_owner_fifo.sv
// Small port-index FIFO used to remember which client owns a read
// return or a pending write beat.
module dram_owner_fifo #(
   parameter int Width = 1,
   parameter int Depth = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] InData,
   input  logic             InValid,
   output logic             InReady,
   output logic [Width-1:0] OutData,
   output logic             OutValid,
   input  logic             OutReady
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_push;
   logic             w_pop;

   // No bypass: a full FIFO refuses a push even while it is popping.
   assign InReady  = (r_cnt != (AW+1)'(Depth));
   assign OutValid = (r_cnt != '0);
   assign OutData  = r_mem[r_rd];
   assign w_push   = InValid & InReady & ~Reset;
   assign w_pop    = OutValid & OutReady & ~Reset;

   always_ff @(posedge Clock) begin
      if (w_push) r_mem[r_wr] <= InData;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin front end merging several DRAM clients onto one MIG-style
// app interface, with in-order read return and write-data steering.
module dram_port_arbiter
   import dram_port_arbiter_pkg::*;
#(
   parameter int NumPorts   = 2,
   parameter int DDRCWidth  = 3,
   parameter int DDRAWidth  = 28,
   parameter int DDRDWidth  = DDR_DWIDTH,
   parameter int DDRMWidth  = DDR_MWIDTH,
   parameter int RdTagDepth = 16,
   parameter int WrOwnDepth = 8,
   parameter bit EnableMask = 1'b1
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [NumPorts*DDRCWidth-1:0] PortCommand,
   input  logic [NumPorts*DDRAWidth-1:0] PortAddress,
   input  logic [NumPorts-1:0]           PortCommandValid,
   output logic [NumPorts-1:0]           PortCommandReady,
   input  logic [NumPorts*DDRDWidth-1:0] PortWriteData,
   input  logic [NumPorts*DDRMWidth-1:0] PortWriteMask,
   input  logic [NumPorts-1:0]           PortWriteDataValid,
   output logic [NumPorts-1:0]           PortWriteDataReady,
   output logic [DDRDWidth-1:0]          PortReadData,
   output logic [NumPorts-1:0]           PortReadDataValid,
   output logic [DDRCWidth-1:0]          DRAMCommand,
   output logic [DDRAWidth-1:0]          DRAMAddress,
   output logic                          DRAMCommandValid,
   input  logic                          DRAMCommandReady,
   output logic [DDRDWidth-1:0]          DRAMWriteData,
   output logic [DDRMWidth-1:0]          DRAMWriteMask,
   output logic                          DRAMWriteDataValid,
   input  logic                          DRAMWriteDataReady,
   input  logic [DDRDWidth-1:0]          DRAMReadData,
   input  logic                          DRAMReadDataValid,
   output logic                          ErrorUnexpectedRead
);

   localparam int PW = $clog2(NumPorts);
   localparam logic [DDRCWidth-1:0] CmdRd = DDRCWidth'(DDR3CMD_READ);
   localparam logic [DDRCWidth-1:0] CmdWr = DDRCWidth'(DDR3CMD_WRITE);

   logic [PW-1:0]        r_rr;
   logic                 r_err;
   logic [DDRCWidth-1:0] w_cmd [NumPorts];
   logic [NumPorts-1:0]  w_elig;
   logic [PW-1:0]        w_grant;
   logic                 w_found;
   logic                 w_acc;
   logic                 w_is_rd;
   logic                 w_is_wr;
   logic                 w_tag_rdy;
   logic                 w_tag_vld;
   logic [PW-1:0]        w_tag_head;
   logic                 w_own_rdy;
   logic                 w_own_vld;
   logic [PW-1:0]        w_own_head;

   // A port is skipped when the FIFO its command needs is full.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NumPorts; i++) begin
         w_cmd[i] = PortCommand[i*DDRCWidth +: DDRCWidth];
         if (w_cmd[i] == CmdRd)
            w_elig[i] = PortCommandValid[i] & w_tag_rdy;
         else if (w_cmd[i] == CmdWr)
            w_elig[i] = PortCommandValid[i] & w_own_rdy;
         else
            w_elig[i] = PortCommandValid[i];
      end
   end

   always_comb begin : p_arb
      int p;
      w_found = 1'b0;
      w_grant = '0;
      p       = 0;
      for (int k = 0; k < NumPorts; k++) begin
         p = (int'(r_rr) + k) % NumPorts;
         if (!w_found && w_elig[p]) begin
            w_found = 1'b1;
            w_grant = PW'(p);
         end
      end
   end

   assign w_is_rd = (w_cmd[w_grant] == CmdRd);
   assign w_is_wr = (w_cmd[w_grant] == CmdWr);
   assign w_acc   = DRAMCommandValid & DRAMCommandReady;

   assign DRAMCommandValid = w_found & ~Reset;
   assign DRAMCommand = Reset ? '0 : w_cmd[w_grant];
   assign DRAMAddress = Reset ? '0
      : PortAddress[w_grant*DDRAWidth +: DDRAWidth];
   assign PortCommandReady = w_acc ? (NumPorts'(1) << w_grant) : '0;

   dram_owner_fifo #(.Width(PW), .Depth(RdTagDepth)) u_tag (
      .Clock    (Clock),
      .Reset    (Reset),
      .InData   (w_grant),
      .InValid  (w_acc & w_is_rd),
      .InReady  (w_tag_rdy),
      .OutData  (w_tag_head),
      .OutValid (w_tag_vld),
      .OutReady (DRAMReadDataValid & ~Reset)
   );

   dram_owner_fifo #(.Width(PW), .Depth(WrOwnDepth)) u_own (
      .Clock    (Clock),
      .Reset    (Reset),
      .InData   (w_grant),
      .InValid  (w_acc & w_is_wr),
      .InReady  (w_own_rdy),
      .OutData  (w_own_head),
      .OutValid (w_own_vld),
      .OutReady (DRAMWriteDataValid & DRAMWriteDataReady)
   );

   assign DRAMWriteDataValid =
      ~Reset & w_own_vld & PortWriteDataValid[w_own_head];
   assign DRAMWriteData = Reset ? '0
      : PortWriteData[w_own_head*DDRDWidth +: DDRDWidth];
   assign DRAMWriteMask = (Reset || !EnableMask) ? '0
      : PortWriteMask[w_own_head*DDRMWidth +: DDRMWidth];
   assign PortWriteDataReady =
      (~Reset & w_own_vld & DRAMWriteDataReady)
      ? (NumPorts'(1) << w_own_head) : '0;

   assign PortReadData = Reset ? '0 : DRAMReadData;
   assign PortReadDataValid =
      (~Reset & DRAMReadDataValid & w_tag_vld)
      ? (NumPorts'(1) << w_tag_head) : '0;
   assign ErrorUnexpectedRead = r_err & ~Reset;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_rr  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_acc) begin
            if (w_grant == PW'(NumPorts-1)) r_rr <= '0;
            else                            r_rr <= w_grant + 1'b1;
         end
         if (DRAMReadDataValid && !w_tag_vld) r_err <= 1'b1;
      end
   end

endmodule
